// File: rtl/boot_loader.sv
// Streams an instruction image into word memory, then releases the core after a
// programmable delay; an image that fills memory without a last-word marker locks up in ERROR.
module boot_loader #(
  parameter int DEPTH_LOG2    = 8,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  In_Valid,
  input  logic [31:0]           In_Data,
  input  logic                  In_Last,
  output logic                  In_Ready,
  output logic                  Mem_WE,
  output logic [31:0]           Mem_Addr,
  output logic [31:0]           Mem_WData,
  output logic                  Core_Reset,
  output logic                  Done,
  output logic                  Overflow,
  output logic [DEPTH_LOG2:0]   Word_Count
);

  localparam logic [DEPTH_LOG2:0] CNT_MAX   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_LAST  = {1'b0, {DEPTH_LOG2{1'b1}}};
  localparam logic [7:0]          HOLD_INIT = 8'(RELEASE_DELAY);

  typedef enum logic [1:0] {LOAD, HOLD, RUN, ERROR} state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_core_reset;
  logic                r_done;
  logic                r_overflow;
  logic [DEPTH_LOG2:0] r_word_count;
  logic [7:0]          r_hold_cnt;

  logic                w_accept;
  logic [31:0]         w_addr;
  logic [DEPTH_LOG2:0] w_count_inc;

  assign w_accept    = In_Valid & r_in_ready;
  assign w_addr      = 32'({r_word_count, 2'b00});
  assign w_count_inc = (r_word_count == CNT_MAX) ? r_word_count : r_word_count + 1'b1;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state      <= LOAD;
      r_in_ready   <= 1'b1;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            r_mem_we     <= 1'b1;
            r_mem_addr   <= w_addr;
            r_mem_wdata  <= In_Data;
            r_word_count <= w_count_inc;
            // A last word always terminates cleanly, even in the final slot.
            if (In_Last) begin
              r_state    <= HOLD;
              r_in_ready <= 1'b0;
              r_hold_cnt <= HOLD_INIT;
            end else if (r_word_count == CNT_LAST) begin
              r_state    <= ERROR;
              r_in_ready <= 1'b0;
              r_overflow <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Release coincides with the counter reaching zero, so Core_Reset
          // drops exactly RELEASE_DELAY cycles after the final write.
          if (r_hold_cnt <= 8'd1) begin
            r_state      <= RUN;
            r_hold_cnt   <= '0;
            r_core_reset <= 1'b0;
            r_done       <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign In_Ready   = r_in_ready;
  assign Mem_WE     = r_mem_we;
  assign Mem_Addr   = r_mem_addr;
  assign Mem_WData  = r_mem_wdata;
  assign Core_Reset = r_core_reset;
  assign Done       = r_done;
  assign Overflow   = r_overflow;
  assign Word_Count = r_word_count;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: a default-size and a 4-word instance share one input stream
// and are checked every cycle against an abstract load/hold/release model.
module tb_boot_loader;

  localparam int RD = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        Reset, In_Valid, In_Last;
  logic [31:0] In_Data;

  logic        b_ready, b_we, b_cr, b_done, b_ovf;
  logic [31:0] b_addr, b_wdata;
  logic [8:0]  b_wc;
  logic        s_ready, s_we, s_cr, s_done, s_ovf;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_wc;

  boot_loader u_big (
    .CLK(CLK), .Reset(Reset), .In_Valid(In_Valid), .In_Data(In_Data), .In_Last(In_Last),
    .In_Ready(b_ready), .Mem_WE(b_we), .Mem_Addr(b_addr), .Mem_WData(b_wdata),
    .Core_Reset(b_cr), .Done(b_done), .Overflow(b_ovf), .Word_Count(b_wc)
  );

  boot_loader #(.DEPTH_LOG2(2), .RELEASE_DELAY(RD)) u_small (
    .CLK(CLK), .Reset(Reset), .In_Valid(In_Valid), .In_Data(In_Data), .In_Last(In_Last),
    .In_Ready(s_ready), .Mem_WE(s_we), .Mem_Addr(s_addr), .Mem_WData(s_wdata),
    .Core_Reset(s_cr), .Done(s_done), .Overflow(s_ovf), .Word_Count(s_wc)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Abstract model: words written, whether the image ended, cycles since the final write.
  int          m_written [2];
  int          m_age     [2];
  bit          m_ended   [2];
  bit          m_ovf     [2];
  bit          m_we      [2];
  logic [31:0] m_addr    [2];
  logic [31:0] m_wdata   [2];
  bit          m_live = 1'b0;
  bit          m_rdy;
  int          m_depth   [2] = '{256, 4};

  always @(posedge CLK) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      m_rdy = !m_ended[i] && !m_ovf[i];
      if (Reset) begin
        m_written[i] = 0; m_age[i] = 0; m_ended[i] = 0; m_ovf[i] = 0;
        m_we[i] = 0; m_addr[i] = 0; m_wdata[i] = 0;
      end else if (m_live) begin
        m_we[i] = m_rdy && In_Valid;
        if (m_we[i]) begin
          m_addr[i]  = 32'(m_written[i] * 4);
          m_wdata[i] = In_Data;
          m_written[i] = (m_written[i] + 1 > m_depth[i]) ? m_depth[i] : m_written[i] + 1;
          if (In_Last) begin
            m_ended[i] = 1; m_age[i] = 0;
          end else if (m_written[i] == m_depth[i]) begin
            m_ovf[i] = 1;
          end
        end else if (m_ended[i] && m_age[i] < 1000) begin
          m_age[i]++;
        end
      end
    end
    if (Reset) m_live = 1'b1;
  end

  typedef struct packed {
    int          c;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t b_log[$];
  wr_t s_log[$];
  int  b_rel = -1;
  int  s_rel = -1;

  task automatic check_dut(input string p, input int i, input logic rdy, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd, input logic cr,
                           input logic dn, input logic ov, input logic [8:0] wc);
    bit run;
    run = m_ended[i] && (m_age[i] >= RD);
    cmp({p, ".In_Ready"},   rdy,  !m_ended[i] && !m_ovf[i]);
    cmp({p, ".Mem_WE"},     we,   m_we[i]);
    cmp({p, ".Mem_Addr"},   addr, m_addr[i]);
    cmp({p, ".Mem_WData"},  wd,   m_wdata[i]);
    cmp({p, ".Core_Reset"}, cr,   !run);
    cmp({p, ".Done"},       dn,   run);
    cmp({p, ".Overflow"},   ov,   m_ovf[i]);
    cmp({p, ".Word_Count"}, wc,   9'(m_written[i]));
  endtask

  always @(negedge CLK) begin
    if (m_live) begin
      check_dut("big",   0, b_ready, b_we, b_addr, b_wdata, b_cr, b_done, b_ovf, b_wc);
      check_dut("small", 1, s_ready, s_we, s_addr, s_wdata, s_cr, s_done, s_ovf, 9'(s_wc));
      if (b_we === 1'b1) b_log.push_back('{cyc, b_addr, b_wdata});
      if (s_we === 1'b1) s_log.push_back('{cyc, s_addr, s_wdata});
      if (b_cr === 1'b0 && b_rel < 0) b_rel = cyc;
      if (s_cr === 1'b0 && s_rel < 0) s_rel = cyc;
    end
  end

  task automatic send(input logic [31:0] d, input logic last);
    In_Valid = 1'b1; In_Data = d; In_Last = last;
    @(posedge CLK); #1;
    In_Valid = 1'b0; In_Last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    b_log.delete(); s_log.delete();
    b_rel = -1; s_rel = -1;
  endtask

  int n;

  initial begin
    Reset = 1'b1; In_Valid = 1'b0; In_Data = '0; In_Last = 1'b0;
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
    cmp("rst.In_Ready", b_ready, 1);
    cmp("rst.Core_Reset", b_cr, 1);
    cmp("rst.Word_Count", b_wc, 0);
    cmp("rst.Mem_Addr", b_addr, 0);

    // Basic three-word load
    send(32'h20080005, 0); send(32'h20090003, 0); send(32'h01095020, 1);
    idle(8);
    cmp("basic.writes", b_log.size(), 3);
    if (b_log.size() == 3) begin
      cmp("basic.addr0", b_log[0].addr, 32'h0);
      cmp("basic.addr1", b_log[1].addr, 32'h4);
      cmp("basic.addr2", b_log[2].addr, 32'h8);
      cmp("basic.data2", b_log[2].data, 32'h01095020);
      cmp("basic.b2b", b_log[2].c - b_log[0].c, 2);
      cmp("basic.release_delay", b_rel - b_log[2].c, 4);
    end
    cmp("basic.Word_Count", b_wc, 3);
    cmp("basic.Done", b_done, 1);

    // Inputs ignored once running
    n = b_log.size();
    In_Valid = 1'b1; In_Data = 32'hDEADBEEF; In_Last = 1'b1;
    idle(10);
    In_Valid = 1'b0; In_Last = 1'b0;
    idle(1);
    cmp("run.no_writes", b_log.size(), n);
    cmp("run.Word_Count", b_wc, 3);
    cmp("run.Core_Reset", b_cr, 0);

    // Gapped valid
    do_reset();
    send(32'h11111111, 0); idle(1); send(32'h22222222, 1);
    idle(8);
    cmp("gap.writes", b_log.size(), 2);
    if (b_log.size() == 2) begin
      cmp("gap.addr1", b_log[1].addr, 32'h4);
      cmp("gap.data1", b_log[1].data, 32'h22222222);
      cmp("gap.spacing", b_log[1].c - b_log[0].c, 2);
    end

    // Overflow on the 4-word instance
    do_reset();
    send(32'hA0, 0); send(32'hA1, 0); send(32'hA2, 0); send(32'hA3, 0);
    In_Valid = 1'b1; In_Data = 32'hBAD; idle(5); In_Valid = 1'b0;
    cmp("ovf.writes", s_log.size(), 4);
    if (s_log.size() == 4) cmp("ovf.addr3", s_log[3].addr, 32'hC);
    cmp("ovf.Overflow", s_ovf, 1);
    cmp("ovf.In_Ready", s_ready, 0);
    cmp("ovf.Core_Reset", s_cr, 1);
    cmp("ovf.Done", s_done, 0);
    cmp("ovf.Word_Count", s_wc, 4);

    // Exact fit on the 4-word instance
    do_reset();
    send(32'hB0, 0); send(32'hB1, 0); send(32'hB2, 0); send(32'hB3, 1);
    idle(8);
    cmp("fit.Overflow", s_ovf, 0);
    cmp("fit.Done", s_done, 1);
    cmp("fit.Word_Count", s_wc, 4);

    // Reset in the middle of a load
    do_reset();
    send(32'h1, 0); send(32'h2, 0);
    Reset = 1'b1; In_Valid = 1'b1; In_Data = 32'h3;
    @(posedge CLK); #1;
    Reset = 1'b0; In_Valid = 1'b0;
    send(32'h4, 1);
    idle(2);
    cmp("midrst.writes", b_log.size(), 3);
    if (b_log.size() == 3) begin
      cmp("midrst.addr", b_log[2].addr, 32'h0);
      cmp("midrst.data", b_log[2].data, 32'h4);
      cmp("midrst.spacing", b_log[2].c - b_log[1].c, 2);
    end
    cmp("midrst.core_held", b_rel, -1);

    // Empty image stays in load
    do_reset();
    idle(20);
    cmp("empty.In_Ready", b_ready, 1);
    cmp("empty.Core_Reset", b_cr, 1);
    cmp("empty.writes", b_log.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, giving a word-memory capacity of DEPTH = 2^DEPTH_LOG2 words.
REQ-002 The block SHALL have parameter RELEASE_DELAY, default 4, giving the cycles between the last write and core release (legal range 1..255).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port In_Valid, input, 1 bit: the upstream word is valid.
REQ-006 The block SHALL have port In_Data, input, 32 bits: the instruction word.
REQ-007 The block SHALL have port In_Last, input, 1 bit: marks the final word of the image.
REQ-008 The block SHALL have port In_Ready, output, 1 bit: the block can accept a word.
REQ-009 The block SHALL have port Mem_WE, output, 1 bit: instruction-memory write strobe.
REQ-010 The block SHALL have port Mem_Addr, output, 32 bits: byte address, word aligned.
REQ-011 The block SHALL have port Mem_WData, output, 32 bits: write data.
REQ-012 The block SHALL have port Core_Reset, output, 1 bit: reset to the processor top, active-high.
REQ-013 The block SHALL have port Done, output, 1 bit: the image is loaded and the core is running.
REQ-014 The block SHALL have port Overflow, output, 1 bit: sticky error indicating the image exceeded DEPTH.
REQ-015 The block SHALL have port Word_Count, output, DEPTH_LOG2+1 bits: the number of words written.

Function
REQ-016 The block SHALL implement the FSM states LOAD, HOLD, RUN and ERROR, with all outputs registered.
REQ-017 The block SHALL accept a word exactly in a cycle where In_Valid=1 and In_Ready=1; at most one word SHALL be accepted per cycle, and back-to-back accepts SHALL be allowed.
REQ-018 In_Ready SHALL be 1 only in LOAD.
REQ-019 For a word accepted in cycle N, the block SHALL drive Mem_WE=1, Mem_WData=In_Data and Mem_Addr={Word_Count_old, 2'b00} zero-extended in cycle N+1, giving a latency of 1.
REQ-020 Mem_WE SHALL be 0 in every cycle not following an accept; Mem_Addr and Mem_WData SHALL hold their last values when Mem_WE=0.
REQ-021 Word_Count SHALL increment by 1 in cycle N+1 for each accepted word and SHALL saturate at DEPTH.
REQ-022 Transition LOAD->HOLD: a word is accepted with In_Last=1 and Word_Count_old < DEPTH; that word SHALL be written normally.
REQ-023 Transition LOAD->ERROR: a word is accepted with In_Last=0 and Word_Count_old = DEPTH-1 (memory full, image unterminated); that word SHALL still be written to address (DEPTH-1)*4.
REQ-024 In HOLD, a down-counter loaded with RELEASE_DELAY SHALL decrement each cycle; when it reaches 0 the FSM SHALL move to RUN.
REQ-025 RUN SHALL be the terminal state until Reset: Core_Reset=0, Done=1, and In_Valid, In_Data and In_Last SHALL be ignored.
REQ-026 ERROR SHALL be the terminal state until Reset: Overflow=1, Core_Reset=1, Done=0, In_Ready=0.
REQ-027 Core_Reset SHALL be 1 in LOAD, HOLD and ERROR, and 0 only in RUN; no single-cycle glitch to 0 SHALL occur.
REQ-028 If In_Valid=1 with no accept (HOLD, RUN, ERROR), no state or output SHALL change.
REQ-029 An empty image (no word ever accepted) SHALL leave the block in LOAD indefinitely with the core held in reset.
REQ-030 When In_Last=1 is accepted at Word_Count_old = DEPTH-1, the FSM SHALL go to HOLD, not ERROR.

Reset
REQ-031 On Reset=1 at a clock edge, the next-cycle values SHALL be: state=LOAD, In_Ready=1, Mem_WE=0, Mem_Addr=0, Mem_WData=0, Core_Reset=1, Done=0, Overflow=0, Word_Count=0, hold counter=0.
REQ-032 Reset SHALL take priority over any simultaneous accept; a word presented in the reset cycle SHALL NOT be written.
REQ-033 Reset asserted mid-load or in RUN SHALL restart loading from address 0 and SHALL re-hold the core.

Verification
REQ-034 Basic load (defaults): three back-to-back words 0x20080005, 0x20090003, 0x01095020 with Last on the third -> Mem_WE high for 3 consecutive cycles at addresses 0x0, 0x4, 0x8; Word_Count=3; Core_Reset falls 4 cycles after the last Mem_WE; Done=1.
REQ-035 Gapped valid: In_Valid toggled 1,0,1 (Last on the second word) -> exactly 2 writes at 0x0 and 0x4 with no spurious Mem_WE in the gap.
REQ-036 Overflow (DEPTH_LOG2=2): 4 words, none with Last -> 4 writes (0x0..0xC); then Overflow=1, In_Ready=0, Core_Reset stays 1, Done=0; a fifth word is never accepted.
REQ-037 Exact fit (DEPTH_LOG2=2): 4 words with Last on the 4th -> HOLD then RUN; Overflow=0; Word_Count=4.
REQ-038 Reset mid-load: after 2 words, Reset=1 for 1 cycle with In_Valid=1 -> no write in the reset cycle; the next accepted word is written at 0x0; Core_Reset remains 1 throughout.
REQ-039 Post-run inputs: in RUN, In_Valid=1 for 10 cycles -> no Mem_WE; Word_Count, Done and Core_Reset remain unchanged.
